// File: rtl/core_control_fsm.sv
// rtl/core_control_fsm.sv - multi-cycle RV32I control unit with debug run/halt handling
module core_control_fsm #(
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic       mem_complete,
  input  logic       branch_taken,
  input  logic       halt_req,
  input  logic       resume_req,
  input  logic       abstract_req,
  output logic       halted,
  output logic       write_pc_ne,
  output logic       write_pc_ex,
  output logic       write_pc,
  output logic       write_ir,
  output logic       write_rd,
  output logic       write_csr,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic [1:0] rd_sel,
  output logic [1:0] alu_insel1,
  output logic [1:0] alu_insel2,
  output logic       abstract_write,
  output logic       abstract_done
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU1_RS = 2'b00;
  localparam logic [1:0] ALU1_PC = 2'b01;
  localparam logic [1:0] ALU1_ZR = 2'b10;
  localparam logic [1:0] ALU2_RS = 2'b00;
  localparam logic [1:0] ALU2_IM = 2'b01;
  localparam logic [1:0] ALU2_IS = 2'b10;
  localparam logic [1:0] RD_ALU  = 2'b00;
  localparam logic [1:0] RD_MEM  = 2'b01;
  localparam logic [1:0] RD_CSR  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_JUMP,
    S_HALTED,
    S_ABSTRACT,
    S_ACK
  } state_e;

  state_e state_q, state_d;
  logic   halted_q, halted_d;

  // State register plus the registered halted flag seen by the debug module
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RESET_HALTED ? S_HALTED : S_FETCH;
      halted_q <= RESET_HALTED;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;

  // Next-state and strobe decode; everything stays at its default while rst is high
  always_comb begin
    state_d        = state_q;
    write_pc_ne    = 1'b0;
    write_pc_ex    = 1'b0;
    write_ir       = 1'b0;
    write_rd       = 1'b0;
    write_csr      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    addr_sel       = 1'b1;
    rd_sel         = RD_ALU;
    alu_insel1     = ALU1_RS;
    alu_insel2     = ALU2_RS;
    abstract_write = 1'b0;
    abstract_done  = 1'b0;

    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          // halt is taken only before the access is issued
          if (halt_req) begin
            state_d = S_HALTED;
          end else begin
            mem_read = 1'b1;
            addr_sel = 1'b1;
            if (mem_complete) begin
              write_ir = 1'b1;
              state_d  = S_EXEC;
            end
          end
        end

        S_EXEC: begin
          state_d = S_FETCH;
          case (opcode)
            OPC_OP: begin
              write_rd    = 1'b1;
              write_pc_ne = 1'b1;
            end
            OPC_OP_IMM: begin
              // shifts take the shamt form of the immediate
              alu_insel2  = (f3 == 3'b001 || f3 == 3'b101) ? ALU2_IS : ALU2_IM;
              write_rd    = 1'b1;
              write_pc_ne = 1'b1;
            end
            OPC_LUI: begin
              alu_insel1  = ALU1_ZR;
              alu_insel2  = ALU2_IM;
              write_rd    = 1'b1;
              write_pc_ne = 1'b1;
            end
            OPC_AUIPC: begin
              alu_insel1  = ALU1_PC;
              alu_insel2  = ALU2_IM;
              write_rd    = 1'b1;
              write_pc_ne = 1'b1;
            end
            OPC_JAL: begin
              // rd receives the link value because write_rd and write_pc_ex coincide
              alu_insel1  = ALU1_PC;
              alu_insel2  = ALU2_IM;
              write_rd    = 1'b1;
              write_pc_ex = 1'b1;
            end
            OPC_JALR: begin
              alu_insel2  = ALU2_IM;
              write_rd    = 1'b1;
              write_pc_ex = 1'b1;
            end
            OPC_BRANCH: begin
              if (branch_taken) begin
                state_d = S_JUMP;
              end else begin
                write_pc_ne = 1'b1;
              end
            end
            OPC_LOAD, OPC_STORE: begin
              state_d = S_MEM;
            end
            OPC_FENCE: begin
              write_pc_ne = 1'b1;
            end
            OPC_SYSTEM: begin
              // f3=000 is the debug break; f3=100 is not a CSR op
              if (f3 == 3'b000 || f3 == 3'b100) begin
                state_d = S_HALTED;
              end else begin
                write_csr   = 1'b1;
                write_rd    = 1'b1;
                rd_sel      = RD_CSR;
                alu_insel1  = f3[2] ? ALU1_ZR : ALU1_RS;
                alu_insel2  = ALU2_IM;
                write_pc_ne = 1'b1;
              end
            end
            default: begin
              state_d = S_HALTED;
            end
          endcase
        end

        S_MEM: begin
          alu_insel1 = ALU1_RS;
          alu_insel2 = ALU2_IM;
          addr_sel   = 1'b0;
          if (opcode == OPC_LOAD) begin
            mem_read = 1'b1;
          end else begin
            mem_write = 1'b1;
          end
          if (mem_complete) begin
            write_pc_ne = 1'b1;
            if (opcode == OPC_LOAD) begin
              write_rd = 1'b1;
              rd_sel   = RD_MEM;
            end
            state_d = S_FETCH;
          end
        end

        S_JUMP: begin
          alu_insel1  = ALU1_PC;
          alu_insel2  = ALU2_IM;
          write_pc_ex = 1'b1;
          state_d     = S_FETCH;
        end

        S_HALTED: begin
          if (abstract_req) begin
            state_d = S_ABSTRACT;
          end else if (resume_req) begin
            state_d = S_FETCH;
          end
        end

        S_ABSTRACT: begin
          abstract_write = 1'b1;
          state_d        = S_ACK;
        end

        S_ACK: begin
          abstract_done = 1'b1;
          state_d       = S_HALTED;
        end

        default: begin
          state_d = S_HALTED;
        end
      endcase
    end

    halted_d = (state_d == S_HALTED) || (state_d == S_ABSTRACT);
    write_pc = write_pc_ne | write_pc_ex;
  end

endmodule

// File: tb/tb_core_control_fsm.sv
// tb/tb_core_control_fsm.sv - scoreboard bench for core_control_fsm
module tb_core_control_fsm;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int N_FETCH = 0;
  localparam int N_JUMP  = 1;
  localparam int N_MEM   = 2;
  localparam int N_HALT  = 3;

  typedef struct packed {
    logic       halted;
    logic       write_pc_ne;
    logic       write_pc_ex;
    logic       write_pc;
    logic       write_ir;
    logic       write_rd;
    logic       write_csr;
    logic       mem_read;
    logic       mem_write;
    logic       addr_sel;
    logic [1:0] rd_sel;
    logic [1:0] alu1;
    logic [1:0] alu2;
    logic       abstract_write;
    logic       abstract_done;
  } out_t;

  typedef struct {
    int   cyc;
    out_t v;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic       mem_complete, branch_taken, halt_req, resume_req, abstract_req;

  logic       halted, write_pc_ne, write_pc_ex, write_pc, write_ir, write_rd, write_csr;
  logic       mem_read, mem_write, addr_sel, abstract_write, abstract_done;
  logic [1:0] rd_sel, alu_insel1, alu_insel2;

  logic       h_halted, h_write_pc_ne, h_write_pc_ex, h_write_pc, h_write_ir, h_write_rd, h_write_csr;
  logic       h_mem_read, h_mem_write, h_addr_sel, h_abstract_write, h_abstract_done;
  logic [1:0] h_rd_sel, h_alu_insel1, h_alu_insel2;

  core_control_fsm #(.RESET_HALTED(1'b0)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .f3(f3), .mem_complete(mem_complete),
    .branch_taken(branch_taken), .halt_req(halt_req), .resume_req(resume_req),
    .abstract_req(abstract_req), .halted(halted), .write_pc_ne(write_pc_ne),
    .write_pc_ex(write_pc_ex), .write_pc(write_pc), .write_ir(write_ir), .write_rd(write_rd),
    .write_csr(write_csr), .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel),
    .rd_sel(rd_sel), .alu_insel1(alu_insel1), .alu_insel2(alu_insel2),
    .abstract_write(abstract_write), .abstract_done(abstract_done)
  );

  core_control_fsm #(.RESET_HALTED(1'b1)) dut_h (
    .clk(clk), .rst(rst), .opcode(opcode), .f3(f3), .mem_complete(mem_complete),
    .branch_taken(branch_taken), .halt_req(halt_req), .resume_req(resume_req),
    .abstract_req(abstract_req), .halted(h_halted), .write_pc_ne(h_write_pc_ne),
    .write_pc_ex(h_write_pc_ex), .write_pc(h_write_pc), .write_ir(h_write_ir), .write_rd(h_write_rd),
    .write_csr(h_write_csr), .mem_read(h_mem_read), .mem_write(h_mem_write), .addr_sel(h_addr_sel),
    .rd_sel(h_rd_sel), .alu_insel1(h_alu_insel1), .alu_insel2(h_alu_insel2),
    .abstract_write(h_abstract_write), .abstract_done(h_abstract_done)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  sb_t  sb_q[$];
  logic exp_h = 1'b0;
  logic prev_h = 1'b0;
  bit   mon_en = 1'b0;
  bit   chk_reset = 1'b0;
  bit   chk_end = 1'b0;
  bit   sess_abs = 1'b0;
  bit   sess_rehalt = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic out_t dflt(input logic h);
    out_t v;
    v          = '0;
    v.addr_sel = 1'b1;
    v.halted   = h;
    return v;
  endfunction

  function automatic logic has_strobe(input out_t v);
    return v.write_pc_ne | v.write_pc_ex | v.write_pc | v.write_ir | v.write_rd | v.write_csr |
           v.mem_read | v.mem_write | v.abstract_write | v.abstract_done;
  endfunction

  // Reference: what the EXEC cycle of an instruction drives, and where it goes next
  function automatic void exec_model(input logic [6:0] op, input logic [2:0] fn3, input logic bt,
                                     output out_t v, output int nxt);
    v   = dflt(1'b0);
    nxt = N_FETCH;
    case (op)
      OPC_OP:     begin v.write_rd = 1; v.write_pc_ne = 1; end
      OPC_OP_IMM: begin v.write_rd = 1; v.write_pc_ne = 1; v.alu2 = (fn3 == 1 || fn3 == 5) ? 2'b10 : 2'b01; end
      OPC_LUI:    begin v.write_rd = 1; v.write_pc_ne = 1; v.alu1 = 2'b10; v.alu2 = 2'b01; end
      OPC_AUIPC:  begin v.write_rd = 1; v.write_pc_ne = 1; v.alu1 = 2'b01; v.alu2 = 2'b01; end
      OPC_JAL:    begin v.write_rd = 1; v.write_pc_ex = 1; v.alu1 = 2'b01; v.alu2 = 2'b01; end
      OPC_JALR:   begin v.write_rd = 1; v.write_pc_ex = 1; v.alu2 = 2'b01; end
      OPC_BRANCH: begin if (bt) nxt = N_JUMP; else v.write_pc_ne = 1; end
      OPC_LOAD, OPC_STORE: nxt = N_MEM;
      OPC_FENCE:  v.write_pc_ne = 1;
      OPC_SYSTEM: begin
        if (fn3 == 3'd0 || fn3 == 3'd4) nxt = N_HALT;
        else begin
          v.write_csr = 1; v.write_rd = 1; v.rd_sel = 2'b10; v.write_pc_ne = 1;
          v.alu1 = fn3[2] ? 2'b10 : 2'b00; v.alu2 = 2'b01;
        end
      end
      default: nxt = N_HALT;
    endcase
    v.write_pc = v.write_pc_ne | v.write_pc_ex;
  endfunction

  // One clock of stimulus: record the expected outputs if they form a visible event
  task automatic cycle(input out_t e);
    sb_t s;
    if (has_strobe(e) || e.halted != exp_h) begin
      s.cyc = cyc;
      s.v   = e;
      sb_q.push_back(s);
    end
    exp_h = e.halted;
    @(posedge clk);
    #1;
    mem_complete = 1'b0;
    abstract_req = 1'b0;
    resume_req   = 1'b0;
  endtask

  // Entered on the first HALTED cycle; leaves with the core about to FETCH
  task automatic halted_session();
    out_t v;
    halt_req     = 1'b0;
    mem_complete = 1'($urandom);
    cycle(dflt(1'b1));
    if (sess_abs) begin
      abstract_req = 1'b1;
      resume_req   = 1'b1;
      cycle(dflt(1'b1));
      v = dflt(1'b1); v.abstract_write = 1'b1; cycle(v);
      v = dflt(1'b0); v.abstract_done  = 1'b1; cycle(v);
      cycle(dflt(1'b1));
    end
    if (sess_rehalt) begin
      halt_req   = 1'b1;
      resume_req = 1'b1;
      cycle(dflt(1'b1));
      cycle(dflt(1'b0));
      halt_req = 1'b0;
      cycle(dflt(1'b1));
    end
    resume_req = 1'b1;
    cycle(dflt(1'b1));
  endtask

  // One full instruction starting in FETCH: fw fetch waits, mw memory waits
  task automatic run_instr(input logic [6:0] op, input logic [2:0] fn3, input logic bt,
                           input int fw, input int mw, input bit hreq);
    out_t v;
    int   nxt;
    opcode       = op;
    f3           = fn3;
    branch_taken = bt;
    for (int i = 0; i < fw; i++) begin
      v = dflt(1'b0); v.mem_read = 1'b1; cycle(v);
    end
    mem_complete = 1'b1;
    v = dflt(1'b0); v.mem_read = 1'b1; v.write_ir = 1'b1; cycle(v);
    exec_model(op, fn3, bt, v, nxt);
    mem_complete = 1'($urandom);
    if (hreq && nxt != N_MEM) halt_req = 1'b1;
    cycle(v);
    case (nxt)
      N_JUMP: begin
        v = dflt(1'b0); v.alu1 = 2'b01; v.alu2 = 2'b01; v.write_pc_ex = 1'b1; v.write_pc = 1'b1;
        cycle(v);
      end
      N_MEM: begin
        for (int i = 0; i <= mw; i++) begin
          if (hreq) halt_req = 1'b1;
          v = dflt(1'b0); v.addr_sel = 1'b0; v.alu2 = 2'b01;
          if (op == OPC_LOAD) v.mem_read = 1'b1; else v.mem_write = 1'b1;
          if (i == mw) begin
            mem_complete = 1'b1;
            v.write_pc_ne = 1'b1; v.write_pc = 1'b1;
            if (op == OPC_LOAD) begin v.write_rd = 1'b1; v.rd_sel = 2'b01; end
          end
          cycle(v);
        end
      end
      N_HALT: halted_session();
      default: ;
    endcase
    if (hreq && nxt != N_HALT) begin
      cycle(dflt(1'b0));
      halted_session();
    end
  endtask

  task automatic reset_in_fetch();
    out_t v;
    v = dflt(1'b0); v.mem_read = 1'b1; cycle(v);
    rst          = 1'b1;
    mem_complete = 1'b1;
    cycle(dflt(1'b0));
    rst = 1'b0;
  endtask

  // Monitor: pops an expectation whenever the DUT shows a strobe or a halted change
  always @(negedge clk) begin
    out_t got, goth;
    sb_t  e;
    got  = '{halted, write_pc_ne, write_pc_ex, write_pc, write_ir, write_rd, write_csr, mem_read,
             mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2, abstract_write, abstract_done};
    goth = '{h_halted, h_write_pc_ne, h_write_pc_ex, h_write_pc, h_write_ir, h_write_rd, h_write_csr,
             h_mem_read, h_mem_write, h_addr_sel, h_rd_sel, h_alu_insel1, h_alu_insel2,
             h_abstract_write, h_abstract_done};
    if (chk_reset) begin
      n_cmp++;
      if (got !== dflt(1'b0)) begin
        n_bad++;
        $display("FAIL reset_outputs got=%h required=%h", got, dflt(1'b0));
      end
      n_cmp++;
      if (goth !== dflt(1'b1)) begin
        n_bad++;
        $display("FAIL reset_halted_variant got=%h required=%h", goth, dflt(1'b1));
      end
    end else if (mon_en && (has_strobe(got) || got.halted !== prev_h)) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d got=%h required=no_event", cyc, got);
      end else begin
        e = sb_q.pop_front();
        if (got !== e.v || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL event got=%h at cyc %0d required=%h at cyc %0d", got, cyc, e.v, e.cyc);
        end
      end
    end
    if (chk_end) begin
      n_cmp++;
      if (sb_q.size() != 0) begin
        n_bad++;
        $display("FAIL missing_events got=%0d pending required=0", sb_q.size());
      end
    end
    prev_h = got.halted;
  end

  logic [6:0] ops [14] = '{OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                           OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_FENCE, OPC_SYSTEM, 7'b1111111,
                           7'b0000000};

  initial begin
    rst          = 1'b1;
    opcode       = '0;
    f3           = '0;
    mem_complete = 1'b0;
    branch_taken = 1'b0;
    halt_req     = 1'b0;
    resume_req   = 1'b0;
    abstract_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset = 1'b0;
    rst       = 1'b0;
    exp_h     = 1'b0;
    mon_en    = 1'b1;

    run_instr(OPC_OP,     3'b000, 1'b0, 0, 0, 1'b0);
    run_instr(OPC_OP_IMM, 3'b001, 1'b0, 0, 0, 1'b0);
    run_instr(OPC_LOAD,   3'b010, 1'b0, 1, 2, 1'b0);
    run_instr(OPC_STORE,  3'b010, 1'b0, 0, 2, 1'b0);
    run_instr(OPC_BRANCH, 3'b000, 1'b0, 0, 0, 1'b0);
    run_instr(OPC_BRANCH, 3'b001, 1'b1, 0, 0, 1'b0);
    run_instr(OPC_JAL,    3'b000, 1'b0, 0, 0, 1'b0);
    sess_abs = 1'b1; sess_rehalt = 1'b1;
    run_instr(OPC_LOAD,   3'b010, 1'b0, 0, 2, 1'b1);
    sess_abs = 1'b0; sess_rehalt = 1'b0;
    run_instr(OPC_SYSTEM, 3'b000, 1'b0, 0, 0, 1'b0);
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0);
    run_instr(OPC_SYSTEM, 3'b101, 1'b0, 0, 0, 1'b0);
    reset_in_fetch();
    run_instr(OPC_OP,     3'b000, 1'b0, 2, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      logic [6:0] op;
      op          = ops[$urandom_range(0, 13)];
      sess_abs    = 1'($urandom);
      sess_rehalt = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 40) == 0) reset_in_fetch();
      run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 3), ($urandom_range(0, 15) == 0));
    end

    mon_en  = 1'b0;
    chk_end = 1'b1;
    @(posedge clk);
    #1;
    chk_end = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
